// File: rtl/ddc_pkg.sv
// ddc_pkg: shared constants and state encoding for the DDC frame readout.
//
// Contents:
//   CH_BITS_DEF, NUM_CH_DEF, FRAME_BITS_DEF - default frame geometry
//   SYNC_STAGES_DEF                         - default pad synchronizer depth
//   TIMEOUT_CYC_DEF                         - default frame timeout (DDC_RX_TIMEOUT_EN builds)
//   ddc_state_e                             - readout state machine encoding

package ddc_pkg;

    localparam int unsigned CH_BITS_DEF     = 20;
    localparam int unsigned NUM_CH_DEF      = 2;
    localparam int unsigned FRAME_BITS_DEF  = CH_BITS_DEF * NUM_CH_DEF;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ddc_state_e;

endpackage

// File: rtl/ddc_sync.sv
// ddc_sync: SYNC_STAGES-deep flip-flop synchronizer for one asynchronous pad input.
//
// Ports:
//   clk - destination clock
//   d   - asynchronous input
//   q   - synchronized output, SYNC_STAGES clk cycles behind d
//
// The chain has no reset on purpose: it keeps tracking the pad while the block is in
// reset, so the edge detector downstream sees the true pad level at reset exit.

module ddc_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages_q;

    if (SYNC_STAGES == 1) begin : g_single
        always_ff @(posedge clk) begin
            stages_q <= d;
        end
    end else begin : g_chain
        always_ff @(posedge clk) begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/ddc_readout.sv
// ddc_readout: reads one DDC converter frame per DVALID_BAR assertion and hands it to a
// valid/ready consumer. Everything runs in the clk domain; SYS_CLK is only sampled.
//
// Sequence: synced DVALID_BAR falls -> latch CONV -> on the next SYS_CLK fall drop
// DXMIT_BAR (opens DCLK at the generator) -> sample DOUT on each following SYS_CLK fall,
// MSB first -> after CH_BITS*NUM_CH samples raise DXMIT_BAR -> deliver the frame.
//
// Ports:
//   clk         100 MHz system clock
//   reset       synchronous, active-high reset
//   SYS_CLK     10 MHz clock level from the generator, edge-detected here
//   CONV        integrator-side select, latched when a frame starts
//   DVALID_BAR  converter data-ready, active low, asynchronous
//   DOUT        converter serial data, asynchronous
//   DXMIT_BAR   transmit enable to generator and converter, active low
//   data_out    captured frame, first received bit at the MSB
//   data_side   CONV level latched at frame start
//   data_valid  frame available
//   data_ready  consumer accepts the frame
//   overrun     sticky: a frame completed while the previous one was still unconsumed
//   timeout_err sticky frame timeout flag (only with DDC_RX_TIMEOUT_EN)
//
// Build option: define DDC_RX_TIMEOUT_EN to add the ARM/SHIFT watchdog, the TIMEOUT_CYC
// parameter and the timeout_err port. Without it the block waits indefinitely.

module ddc_readout
    import ddc_pkg::*;
#(
    parameter int unsigned CH_BITS     = CH_BITS_DEF,
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
`ifdef DDC_RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      SYS_CLK,
    input  logic                      CONV,
    input  logic                      DVALID_BAR,
    input  logic                      DOUT,
    output logic                      DXMIT_BAR,
    output logic [CH_BITS*NUM_CH-1:0] data_out,
    output logic                      data_side,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      overrun
`ifdef DDC_RX_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int unsigned FRAME_BITS = CH_BITS * NUM_CH;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

    // ---------------------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------------------
    logic dvalid_s;
    logic dout_s;
    logic dvalid_prev_q;
    logic sys_prev_q;
    logic dvalid_fall;
    logic sys_fall;

    ddc_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_dvalid (
        .clk(clk),
        .d  (DVALID_BAR),
        .q  (dvalid_s)
    );

    ddc_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_dout (
        .clk(clk),
        .d  (DOUT),
        .q  (dout_s)
    );

    // Edge-detect history keeps running through reset, so a DVALID_BAR that is already
    // low when reset drops is seen as a level and not as a fresh falling edge.
    always_ff @(posedge clk) begin
        dvalid_prev_q <= dvalid_s;
        sys_prev_q    <= SYS_CLK;
    end

    assign dvalid_fall = dvalid_prev_q & ~dvalid_s;
    assign sys_fall    = sys_prev_q & ~SYS_CLK;

    // ---------------------------------------------------------------------------------
    // Frame state machine, all outputs registered
    // ---------------------------------------------------------------------------------
    ddc_state_e            state_q;
    logic [CNT_W-1:0]      bitcnt_q;
    logic [CNT_W-1:0]      bitcnt_inc;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  side_q;

    assign bitcnt_inc = bitcnt_q + CNT_W'(1);

`ifdef DDC_RX_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    // Abort on the TIMEOUT_CYC-th clk spent in ARM/SHIFT.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            side_q     <= 1'b0;
            DXMIT_BAR  <= 1'b1;
            data_out   <= '0;
            data_side  <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef DDC_RX_TIMEOUT_EN
            timer_q     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // Consumer handshake; DONE below may re-assert data_valid in the same cycle.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (dvalid_fall) begin
                        side_q  <= CONV;
                        state_q <= ARM;
                    end
                end

                ARM: begin
                    // Opening DCLK on a SYS_CLK fall lets the generator's next rise be
                    // the first gated DCLK edge the converter sees.
                    if (sys_fall) begin
                        DXMIT_BAR <= 1'b0;
                        bitcnt_q  <= '0;
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (sys_fall) begin
                        shift_q  <= {shift_q[FRAME_BITS-2:0], dout_s};
                        bitcnt_q <= bitcnt_inc;
                        if (bitcnt_inc == LAST_CNT) begin
                            DXMIT_BAR <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (!data_valid || data_ready) begin
                        data_out   <= shift_q;
                        data_side  <= side_q;
                        data_valid <= 1'b1;
                    end else begin
                        // Previous frame still held: keep it, drop the new one.
                        overrun <= 1'b1;
                    end
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

`ifdef DDC_RX_TIMEOUT_EN
            if (state_q == ARM || state_q == SHIFT) begin
                if (timer_q == TMR_LAST) begin
                    // Overrides any shift-state update made above this cycle.
                    state_q     <= IDLE;
                    DXMIT_BAR   <= 1'b1;
                    timeout_err <= 1'b1;
                    timer_q     <= '0;
                end else begin
                    timer_q <= timer_q + TMR_W'(1);
                end
            end else begin
                timer_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ddc_readout.sv
// tb_ddc_readout: randomized bench for ddc_readout with a clock-generator/converter model
// and a scoreboard. Stimulus pushes expected frames; a monitor pops and compares them at
// every data_valid & data_ready handshake.

module tb_ddc_readout;

    localparam int unsigned CH_BITS = 20;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned FB      = CH_BITS * NUM_CH;
`ifdef DDC_RX_TIMEOUT_EN
    // A full frame needs about 410 clk, so the watchdog must sit above that.
    localparam int unsigned TB_TIMEOUT = 600;
`endif

    logic          clk;
    logic          reset;
    logic          SYS_CLK;
    logic          CONV;
    logic          DVALID_BAR;
    logic          DOUT;
    logic          DXMIT_BAR;
    logic [FB-1:0] data_out;
    logic          data_side;
    logic          data_valid;
    logic          data_ready;
    logic          overrun;
`ifdef DDC_RX_TIMEOUT_EN
    logic          timeout_err;
`endif

    ddc_readout #(
        .CH_BITS    (CH_BITS),
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(2)
`ifdef DDC_RX_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TB_TIMEOUT)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SYS_CLK   (SYS_CLK),
        .CONV      (CONV),
        .DVALID_BAR(DVALID_BAR),
        .DOUT      (DOUT),
        .DXMIT_BAR (DXMIT_BAR),
        .data_out  (data_out),
        .data_side (data_side),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .overrun   (overrun)
`ifdef DDC_RX_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [FB-1:0] data;
        logic          side;
    } frame_t;

    frame_t exp_q[$];
    bit     model_pending = 0;
    bit     model_overrun = 0;

    logic [FB-1:0] ddc_word = '0;
    int            ddc_idx;
    int            xmit_falls = 0;
    bit            sys_run = 1;
    wire           dclk = SYS_CLK & ~DXMIT_BAR;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference model of the delivery rules: a finished frame is handed over when the
    // output slot is free or being emptied in the same cycle, otherwise it is lost.
    task automatic model_complete(input logic [FB-1:0] w, input logic side, input bit rdy);
        frame_t f;
        if (!model_pending || rdy) begin
            f.data = w;
            f.side = side;
            exp_q.push_back(f);
            model_pending = 1;
        end else begin
            model_overrun = 1;
        end
    endtask

    task automatic model_reset();
        model_pending = 0;
        model_overrun = 0;
        exp_q.delete();
    endtask

    // Clocks
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        SYS_CLK = 0;
        forever begin
            repeat (5) @(posedge clk);
            #1;
            if (sys_run) SYS_CLK = ~SYS_CLK;
        end
    end

    // Converter model: next bit on every gated DCLK rise; frame pointer rewinds when
    // DXMIT_BAR closes.
    initial begin
        DOUT    = 0;
        ddc_idx = 0;
        forever begin
            @(posedge dclk or posedge DXMIT_BAR);
            if (DXMIT_BAR) begin
                ddc_idx = 0;
            end else begin
                if (ddc_idx < int'(FB)) DOUT = ddc_word[FB-1-ddc_idx];
                ddc_idx++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge SYS_CLK);
            if (DXMIT_BAR == 1'b0) xmit_falls++;
        end
    end

    // Scoreboard monitor
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got 0x%0h, want no frame", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", 64'(data_out), 64'(e.data));
                    check("frame_side", 64'(data_side), 64'(e.side));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    task automatic wait_xmit(input logic level, input int budget, input string name,
                             output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (DXMIT_BAR == level) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: DXMIT_BAR not %0b after %0d clk", name, level, budget);
    endtask

    task automatic start_frame(input logic [FB-1:0] w, input logic conv);
        ddc_word   = w;
        CONV       = conv;
        xmit_falls = 0;
        repeat ($urandom_range(0, 9)) @(posedge clk);
        #1;
        DVALID_BAR = 0;
        repeat (3) @(posedge clk);
        #1;
        DVALID_BAR = 1;
    endtask

    task automatic run_frame(input logic [FB-1:0] w, input logic conv, input bit rdy_done);
        bit ok;
        start_frame(w, conv);
        wait_xmit(1'b0, 40, "xmit_open", ok);
        if (!ok) return;
        CONV = ~conv;  // must not leak into data_side
        wait_xmit(1'b1, FB * 10 + 40, "xmit_close", ok);
        if (!ok) return;
        // Now one clk after the last sample; DONE acts on the next edge.
        if (!model_pending) check("valid_early", 64'(data_valid), 64'd0);
        if (rdy_done) data_ready = 1;
        @(posedge clk);
        #1;
        data_ready = 0;
        check("valid_latency", 64'(data_valid), 64'd1);
        check("xmit_falls", 64'(xmit_falls), 64'(FB));
        model_complete(w, conv, rdy_done);
    endtask

    task automatic consume();
        data_ready = 1;
        @(posedge clk);
        #1;
        data_ready   = 0;
        model_pending = 0;
    endtask

    function automatic logic [FB-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[FB-1:0];
    endfunction

    initial begin
        logic [FB-1:0] w;
        logic [FB-1:0] word_a;
        bit            ok;
        int            low_cycles;
        int            cyc;

        word_a     = 40'hABCDE12345;
        reset      = 1;
        CONV       = 0;
        DVALID_BAR = 1;
        data_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dxmit", 64'(DXMIT_BAR), 64'd1);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_side", 64'(data_side), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
`ifdef DDC_RX_TIMEOUT_EN
        check("rst_timeout", 64'(timeout_err), 64'd0);
`endif
        reset = 0;
        repeat (3) @(posedge clk);

        // Normal frame, left unconsumed
        run_frame(word_a, 1'b1, 1'b0);
        check("a_data", 64'(data_out), 64'(word_a));
        check("a_side", 64'(data_side), 64'd1);
        check("a_overrun", 64'(overrun), 64'd0);

        // Back-pressure: second frame is dropped
        run_frame(40'hFFFFF00000, 1'b0, 1'b0);
        check("bp_overrun", 64'(overrun), 64'(model_overrun));
        check("bp_data_kept", 64'(data_out), 64'(word_a));
        check("bp_side_kept", 64'(data_side), 64'd1);
        consume();
        check("bp_valid_drop", 64'(data_valid), 64'd0);

        // Consume in the DONE cycle of the following frame
        run_frame(rand_word(), 1'($urandom_range(0, 1)), 1'b0);
        w = rand_word();
        run_frame(w, 1'b0, 1'b1);
        check("sim_valid", 64'(data_valid), 64'd1);
        check("sim_data", 64'(data_out), 64'(w));
        check("sim_overrun", 64'(overrun), 64'(model_overrun));
        consume();

        // Reset mid-frame
        start_frame(rand_word(), 1'b1);
        wait_xmit(1'b0, 40, "mid_open", ok);
        for (int i = 0; i < 400 && xmit_falls < 17; i++) @(posedge clk);
        check("mid_reached_17", 64'(xmit_falls >= 17), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        check("mid_dxmit", 64'(DXMIT_BAR), 64'd1);
        check("mid_valid", 64'(data_valid), 64'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        check("mid_overrun", 64'(overrun), 64'd0);
        run_frame(rand_word(), 1'b1, 1'b0);
        consume();

        // DVALID_BAR already low when reset drops
        #1;
        reset      = 1;
        DVALID_BAR = 0;
        repeat (5) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        low_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!DXMIT_BAR) low_cycles++;
        end
        check("lowstart_no_frame", 64'(low_cycles), 64'd0);
        check("lowstart_no_valid", 64'(data_valid), 64'd0);
        DVALID_BAR = 1;
        repeat (4) @(posedge clk);
        run_frame(rand_word(), 1'b0, 1'b0);
        consume();

        // Randomized traffic with random back-pressure
        for (int n = 0; n < 8; n++) begin
            run_frame(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) consume();
        end
        if (model_pending) consume();
        check("rand_overrun", 64'(overrun), 64'(model_overrun));

`ifdef DDC_RX_TIMEOUT_EN
        // Freeze SYS_CLK mid-frame; the watchdog must abort
        start_frame(rand_word(), 1'b0);
        wait_xmit(1'b0, 40, "to_open", ok);
        cyc = 0;
        for (int i = 0; i < 100 && xmit_falls < 5; i++) begin
            @(posedge clk);
            cyc++;
        end
        sys_run = 0;
        for (int i = 0; i < 2 * int'(TB_TIMEOUT) && !timeout_err; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("to_flag", 64'(timeout_err), 64'd1);
        check("to_window", 64'(cyc >= int'(TB_TIMEOUT) - 20 && cyc <= int'(TB_TIMEOUT)),
              64'd1);
        check("to_dxmit", 64'(DXMIT_BAR), 64'd1);
        check("to_valid", 64'(data_valid), 64'd0);
        sys_run = 1;
        repeat (12) @(posedge clk);
        run_frame(rand_word(), 1'b1, 1'b0);
        consume();
        check("to_sticky", 64'(timeout_err), 64'd1);
`else
        cyc = 0;
`endif

        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
